div_period_monitor: RTL and testbench

Checks the divider's `clk_out` in the system clock domain. The block synchronizes the divided signal, detects its rising edges and measures each period in `clk` cycles. It declares lock after a run of in-tolerance periods and flags loss of lock with a sticky error and a saturating error count. It sits directly downstream of the clock divider and drives status and debug logic.

---
 rtl/div_period_monitor.sv | 163 ++++++++++++++++
 tb/tb_div_period_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/div_period_monitor.sv
// div_period_monitor: supervises a divided clock in the system clock domain.
// The divided signal is synchronized and its rising edges are detected. Each
// period is then measured in clk cycles. Lock is declared after LOCK_CNT
// consecutive in-tolerance periods. Loss of lock sets a sticky error flag and
// increments a saturating event counter.
//
// Ports:
//   clk        system clock, all registers on rising edge
//   reset      asynchronous active-high reset
//   div_in     divided clock, treated as asynchronous data
//   en         monitor enable; low forces IDLE
//   err_clr    single-cycle pulse clearing err and err_cnt
//   period     last measured period (clk cycles)
//   period_vld one-cycle pulse when period updates
//   locked     high while in LOCKED
//   err        sticky loss-of-lock flag
//   err_cnt    loss-of-lock event count, saturating at 255
module div_period_monitor #(
    parameter int unsigned EXP_PERIOD = 8,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_in,
    input  logic             en,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int unsigned GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

    localparam logic [CNT_W-1:0]  LO_LIM    = CNT_W'((EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0);
    localparam logic [CNT_W-1:0]  HI_LIM    = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  STALL_LIM = CNT_W'(EXP_PERIOD + TOL + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [7:0]        ERR_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t            state;
    logic              s1;
    logic              s2;
    logic              s3;
    logic [CNT_W-1:0]  cnt;
    logic [GOOD_W-1:0] good_cnt;

    logic rise;
    logic good;
    logic loss;

    // Edge detect on the synchronized level.
    assign rise = s2 & ~s3;

    // Current count falls inside the tolerance window.
    assign good = (cnt >= LO_LIM) && (cnt <= HI_LIM);

    // Loss of lock: a bad period, or no edge by one cycle past the window.
    assign loss = en && (state == LOCKED) && (rise ? !good : (cnt == STALL_LIM));

    // Synchronizer, period counter, FSM and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            good_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            s1         <= div_in;
            s2         <= s1;
            s3         <= s2;
            period_vld <= 1'b0;

            // An event in the same cycle as err_clr leaves exactly one count.
            if (loss) begin
                err <= 1'b1;
                if (err_clr) begin
                    err_cnt <= 8'd1;
                end else if (err_cnt != ERR_MAX) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (err_clr) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end

            if (!en) begin
                state    <= IDLE;
                cnt      <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                if (rise) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end

                case (state)
                    IDLE: begin
                        state <= ARM;
                    end
                    ARM: begin
                        // First edge only starts the count; nothing to measure yet.
                        if (rise) begin
                            state <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (rise) begin
                            period     <= cnt;
                            period_vld <= 1'b1;
                            if (good) begin
                                if (good_cnt == GOOD_LAST) begin
                                    state    <= LOCKED;
                                    locked   <= 1'b1;
                                    good_cnt <= '0;
                                end else begin
                                    good_cnt <= good_cnt + GOOD_W'(1);
                                end
                            end else begin
                                good_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (rise) begin
                            period     <= cnt;
                            period_vld <= 1'b1;
                        end
                        if (loss) begin
                            state    <= TRACK;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_period_monitor.sv
// tb_div_period_monitor: directed bench for div_period_monitor with default
// parameters. Waveforms are driven one clk step at a time; per-wave statistics
// are collected and compared against hand-computed cycle positions.
module tb_div_period_monitor;

    logic        clk;
    logic        reset;
    logic        div_in;
    logic        en;
    logic        err_clr;
    logic [15:0] period;
    logic        period_vld;
    logic        locked;
    logic        err;
    logic [7:0]  err_cnt;

    int n_checks;
    int n_pass;

    // Per-wave statistics.
    int w_vld;
    int w_first_k;
    int w_first_per;
    int w_last_per;
    int w_lock_k;
    int w_err_seen;

    div_period_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .div_in     (div_in),
        .en         (en),
        .err_clr    (err_clr),
        .period     (period),
        .period_vld (period_vld),
        .locked     (locked),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        en      = 1'b0;
        div_in  = 1'b0;
        err_clr = 1'b0;
        tick(2);
        reset = 1'b0;
        en    = 1'b1;
        tick(2);
    endtask

    // Drive n steps of a wave of period per with hi high cycles, starting high
    // at step 1. Step k ends just after clock edge k; err_clr pulses at clr_k.
    task automatic wave(input int per, input int hi, input int n, input int clr_k);
        logic prev_locked;
        w_vld       = 0;
        w_first_k   = 0;
        w_first_per = 0;
        w_last_per  = 0;
        w_lock_k    = 0;
        w_err_seen  = 0;
        prev_locked = locked;
        for (int k = 1; k <= n; k++) begin
            div_in  = (((k - 1) % per) < hi);
            err_clr = (k == clr_k);
            @(posedge clk);
            #1;
            if (period_vld) begin
                w_vld++;
                if (w_first_k == 0) begin
                    w_first_k   = k;
                    w_first_per = int'(period);
                end
                w_last_per = int'(period);
            end
            if (locked && !prev_locked && w_lock_k == 0) w_lock_k = k;
            prev_locked = locked;
            if (err) w_err_seen = 1;
        end
        err_clr = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        en       = 1'b0;
        div_in   = 1'b0;
        err_clr  = 1'b0;
        #2;
        check("rst_period", 32'(period), 0);
        check("rst_vld", 32'(period_vld), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);

        // 1: nominal period 8 (4 high / 4 low).
        do_reset();
        wave(8, 4, 40, 0);
        check("t1_first_vld_k", 32'(w_first_k), 11);
        check("t1_first_per", 32'(w_first_per), 8);
        check("t1_vld_cnt", 32'(w_vld), 4);
        check("t1_lock_k", 32'(w_lock_k), 35);
        check("t1_err_seen", 32'(w_err_seen), 0);

        // 2: period 9 locks, period 10 does not.
        do_reset();
        wave(9, 4, 45, 0);
        check("t2_9_first_vld_k", 32'(w_first_k), 12);
        check("t2_9_last_per", 32'(w_last_per), 9);
        check("t2_9_lock_k", 32'(w_lock_k), 39);
        do_reset();
        wave(10, 5, 50, 0);
        check("t2_10_vld_cnt", 32'(w_vld), 4);
        check("t2_10_last_per", 32'(w_last_per), 10);
        check("t2_10_lock_k", 32'(w_lock_k), 0);
        check("t2_10_locked", 32'(locked), 0);
        check("t2_10_err_seen", 32'(w_err_seen), 0);

        // 3: stall in LOCKED, then recovery.
        do_reset();
        wave(8, 4, 40, 0);
        check("t3_lock_k", 32'(w_lock_k), 35);
        tick(4);
        check("t3_pre_stall_locked", 32'(locked), 1);
        check("t3_pre_stall_err", 32'(err), 0);
        tick(1);
        check("t3_stall_locked", 32'(locked), 0);
        check("t3_stall_err", 32'(err), 1);
        check("t3_stall_err_cnt", 32'(err_cnt), 1);
        wave(8, 4, 40, 0);
        check("t3_relock_first_k", 32'(w_first_k), 3);
        check("t3_relock_first_per", 32'(w_first_per), 13);
        check("t3_relock_vld_cnt", 32'(w_vld), 5);
        check("t3_relock_lock_k", 32'(w_lock_k), 35);

        // 4: short period in LOCKED, err_clr alone, err_clr colliding with an event.
        wave(6, 3, 6, 2);
        check("t4_a_first_per", 32'(w_first_per), 8);
        check("t4_a_locked", 32'(locked), 1);
        check("t4_clr_err", 32'(err), 0);
        check("t4_clr_err_cnt", 32'(err_cnt), 0);
        wave(8, 4, 40, 0);
        check("t4_b_first_k", 32'(w_first_k), 3);
        check("t4_b_first_per", 32'(w_first_per), 6);
        check("t4_b_err", 32'(err), 1);
        check("t4_b_err_cnt", 32'(err_cnt), 1);
        check("t4_b_lock_k", 32'(w_lock_k), 35);
        wave(6, 3, 6, 0);
        wave(8, 4, 40, 3);
        check("t4_d_first_per", 32'(w_first_per), 6);
        check("t4_d_err", 32'(err), 1);
        check("t4_d_err_cnt", 32'(err_cnt), 1);
        check("t4_d_lock_k", 32'(w_lock_k), 35);

        // 5: drop en mid-lock, then async reset mid-lock.
        en = 1'b0;
        tick(1);
        check("t5_en_locked", 32'(locked), 0);
        check("t5_en_period", 32'(period), 8);
        check("t5_en_err", 32'(err), 1);
        check("t5_en_err_cnt", 32'(err_cnt), 1);
        en = 1'b1;
        wave(8, 4, 40, 0);
        check("t5_reen_first_k", 32'(w_first_k), 11);
        check("t5_reen_lock_k", 32'(w_lock_k), 35);
        #3;
        reset = 1'b1;
        #1;
        check("t5_rst_period", 32'(period), 0);
        check("t5_rst_locked", 32'(locked), 0);
        check("t5_rst_err", 32'(err), 0);
        check("t5_rst_err_cnt", 32'(err_cnt), 0);
        check("t5_rst_vld", 32'(period_vld), 0);

        // 6: single-cycle pulses, then saturating error count.
        do_reset();
        wave(8, 1, 40, 0);
        check("t6_pulse_last_per", 32'(w_last_per), 8);
        check("t6_pulse_vld_cnt", 32'(w_vld), 4);
        check("t6_pulse_lock_k", 32'(w_lock_k), 35);
        for (int i = 1; i <= 260; i++) begin
            wave(6, 3, 6, 0);
            wave(8, 4, 40, 0);
            if (i == 254) check("t6_err_cnt_254", 32'(err_cnt), 254);
        end
        check("t6_err_cnt_sat", 32'(err_cnt), 255);
        check("t6_sat_err", 32'(err), 1);
        check("t6_sat_locked", 32'(locked), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
